// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: the FSM state encoding and
// the line-level constants.
//   uart_tx_state_t : IDLE, START, DATA, PARITY, STOP
//   UART_DATA_BITS  : payload width (8)
//   UART_IDLE_LEVEL : level of an idle line / stop bit (1)
//   UART_START_LEVEL: level of the start bit (0)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Groups the button/payload inputs and the serial-line/status outputs of the
// frame transmitter.
//   transmit : debounced button level (synchronous to clk)
//   data     : payload word, sampled at frame start
//   txd      : serial line, idle high
//   busy     : frame in progress
//   done     : one-cycle pulse at the end of the stop bit
// Modports: master = stimulus side (drives transmit/data),
//           slave  = transmitter (drives txd/busy/done).
// ---------------------------------------------------------------------------
interface uart_tx_frame_if;
    import uart_pkg::*;

    logic                      transmit;
    logic [UART_DATA_BITS-1:0] data;
    logic                      txd;
    logic                      busy;
    logic                      done;

    modport master (
        output transmit,
        output data,
        input  txd,
        input  busy,
        input  done
    );

    modport slave (
        input  transmit,
        input  data,
        output txd,
        output busy,
        output done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high during
// the last count of each bit period.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous clear, holds the counter at 0 while high
//   tick  : high on the last count of a bit period (never while clear)
// ---------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clear || (cnt_reg == CNT_LAST)) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = !clear && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Sends one UART frame (start, 8 data bits LSB first, [parity], stop) per
// rising edge of the debounced transmit level. The payload is latched at the
// frame start; triggers outside IDLE are ignored.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : uart_tx_frame_if.slave (transmit, data in; txd, busy, done out)
// Build option: define UART_TX_PARITY_EN for 8E1 frames (even parity bit
// between the data bits and the stop bit); default build is 8N1.
// ---------------------------------------------------------------------------
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_frame_if.slave   bus
);

    localparam logic [2:0] IDX_LAST = 3'(DATA_BITS - 1);

    uart_tx_state_t       state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [2:0]           idx_reg,   idx_next;
    logic                 txd_reg,   txd_next;
    logic                 busy_reg,  busy_next;
    logic                 done_reg,  done_next;
    logic                 trans_q_reg;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg, parity_next;
`endif

    logic tick;
    logic trigger;

    // Counter is parked at 0 while idle so the start bit gets a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_reg == IDLE),
        .tick  (tick)
    );

    assign trigger = bus.transmit & ~trans_q_reg;

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        txd_next   = txd_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (trigger) begin
                    shift_next = bus.data;
                    idx_next   = '0;
                    txd_next   = UART_START_LEVEL;
                    busy_next  = 1'b1;
                    state_next = START;
`ifdef UART_TX_PARITY_EN
                    parity_next = ^bus.data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    txd_next   = shift_reg[0];
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    idx_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx_reg == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        txd_next   = parity_reg;
                        state_next = PARITY;
`else
                        txd_next   = UART_IDLE_LEVEL;
                        state_next = STOP;
`endif
                    end else begin
                        txd_next   = shift_reg[0];
                        shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                        idx_next   = idx_reg + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    txd_next   = UART_IDLE_LEVEL;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // A trigger on this cycle is dropped: it is only looked at in IDLE.
                if (tick) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                txd_next   = UART_IDLE_LEVEL;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    // trans_q resets high so a button held through reset cannot fire a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            idx_reg     <= '0;
            txd_reg     <= UART_IDLE_LEVEL;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            trans_q_reg <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            idx_reg     <= idx_next;
            txd_reg     <= txd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            trans_q_reg <= bus.transmit;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign bus.txd  = txd_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame with CLKS_PER_BIT=4. Expected frames are
// written out bit by bit in line order (leftmost bit goes out first).
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;
    import uart_pkg::*;

    localparam int CPB = 4;

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    //                                  start data(LSB first) par stop
    localparam logic [0:10] FR_A5 = 11'b0_10100101_0_1;
    localparam logic [0:10] FR_3C = 11'b0_00111100_0_1;
    localparam logic [0:10] FR_01 = 11'b0_10000000_1_1;
`else
    localparam int NBITS = 10;
    //                                  start data(LSB first) stop pad
    localparam logic [0:10] FR_A5 = 11'b0_10100101_1_1;
    localparam logic [0:10] FR_3C = 11'b0_00111100_1_1;
    localparam logic [0:10] FR_01 = 11'b0_10000000_1_1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   err_cnt = 0;
    int   chk_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_frame_if bus ();

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line must stay idle for ncyc cycles.
    task automatic check_idle(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_eq({tag, " txd"},  32'(bus.txd),  32'd1);
            check_eq({tag, " busy"}, 32'(bus.busy), 32'd0);
            check_eq({tag, " done"}, 32'(bus.done), 32'd0);
        end
        $display("idle   %-10s %0d cycles", tag, ncyc);
    endtask

    // Raise transmit with data d and check every cycle of the frame, then the
    // done pulse. With disturb set, the button is toggled and data changed
    // mid-frame, and a fresh edge is placed on the STOP->IDLE cycle.
    task automatic send_frame(input string tag, input logic [7:0] d,
                              input logic [0:10] exp, input bit disturb);
        int last_k;
        last_k = NBITS * CPB - 1;
        bus.data     = d;
        bus.transmit = 1'b1;
        for (int k = 0; k <= last_k; k++) begin
            @(negedge clk);
            check_eq($sformatf("%s txd bit%0d c%0d", tag, k / CPB, k), 32'(bus.txd), 32'(exp[k / CPB]));
            check_eq($sformatf("%s busy c%0d", tag, k), 32'(bus.busy), 32'd1);
            check_eq($sformatf("%s done c%0d", tag, k), 32'(bus.done), 32'd0);
            if (disturb) begin
                if (k == 5)      bus.transmit = 1'b0;
                if (k == 9)      bus.transmit = 1'b1;
                if (k == 12)     bus.data     = ~d;
                if (k == 30)     bus.transmit = 1'b0;
                if (k == last_k) bus.transmit = 1'b1;
            end
        end
        @(negedge clk);
        check_eq({tag, " done pulse"},  32'(bus.done), 32'd1);
        check_eq({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        check_eq({tag, " txd at done"},  32'(bus.txd),  32'd1);
        @(negedge clk);
        check_eq({tag, " done width"},  32'(bus.done), 32'd0);
        check_eq({tag, " busy after"},  32'(bus.busy), 32'd0);
        $display("frame  %-10s data=%02h bits=%0d errors_so_far=%0d", tag, d, NBITS, err_cnt);
    endtask

    initial begin
        bus.transmit = 1'b0;
        bus.data     = '0;

        // Reset values while held in reset, then 20 idle cycles after release.
        repeat (3) @(negedge clk);
        check_eq("rst txd",  32'(bus.txd),  32'd1);
        check_eq("rst busy", 32'(bus.busy), 32'd0);
        check_eq("rst done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        check_idle("post_rst", 20);

        // Basic frame.
        send_frame("a5", 8'hA5, FR_A5, 1'b0);

        // Held button: no retrigger for the rest of the 200 cycles.
        check_idle("hold", 200 - NBITS * CPB - 2);
        bus.transmit = 1'b0;
        check_idle("release", 3);
        send_frame("3c", 8'h3C, FR_3C, 1'b0);
        bus.transmit = 1'b0;
        check_idle("gap1", 3);

        // Toggles and data change mid-frame, edge on the STOP->IDLE cycle.
        send_frame("toggle", 8'hA5, FR_A5, 1'b1);
        check_idle("no_extra", 30);
        bus.transmit = 1'b0;
        check_idle("gap2", 3);

        // Reset at cycle 15 of a frame, button held through reset.
        bus.data     = 8'hA5;
        bus.transmit = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("pre-rst busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst txd",  32'(bus.txd),  32'd1);
        check_eq("midrst busy", 32'(bus.busy), 32'd0);
        check_eq("midrst done", 32'(bus.done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_eq("in-rst done", 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        check_idle("held_rst", 60);
        bus.transmit = 1'b0;
        check_idle("gap3", 3);

        // Odd-parity-count payload.
        send_frame("01", 8'h01, FR_01, 1'b0);
        bus.transmit = 1'b0;
        check_idle("tail", 5);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
